// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
// Shared types and helpers for the Wishbone register-bank slave:
//   state_t      - slave FSM states (IDLE, WAIT, RESP, HOLD)
//   resp_kind_t  - response kind latched at accept time (OK, ERR)
//   addr_lsb()   - number of byte-offset bits below the word index
//   idx_width()  - width of a word index that can also name the status word
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } state_t;

  typedef enum logic {
    OK,
    ERR
  } resp_kind_t;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Index NUM_REGS (the status word) must be representable, hence +1.
  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs + 1);
  endfunction

endpackage

// File: rtl/wb_regfile_slave_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_slave_if
// Classic-cycle Wishbone bus bundle between a master and the register bank.
//   master -> slave : cyc, stb, we, addr, wdata, sel
//   slave -> master : stall, ack, rdata, err
// ---------------------------------------------------------------------------
interface wb_regfile_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic                      stall;
  logic                      ack;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      err;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, rdata, err
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, rdata, err
  );

endinterface

// File: rtl/wb_regfile_decode.sv
// ---------------------------------------------------------------------------
// wb_regfile_decode
// Combinational address decode for the register bank.
//   i_addr   - byte address from the bus
//   i_we     - write enable from the bus
//   o_index  - word index (0..NUM_REGS, NUM_REGS = read-only status word)
//   o_kind   - ERR if misaligned, beyond the status word, or a status write
// ---------------------------------------------------------------------------
module wb_regfile_decode
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic                           i_we,
  output logic [idx_width(NUM_REGS)-1:0] o_index,
  output resp_kind_t                     o_kind
);

  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = idx_width(NUM_REGS);

  // Works for ADDR_LSB = 0 too, where the mask is empty and nothing is misaligned.
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

  logic [ADDR_WIDTH-1:0] w_full_idx;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_ro_write;

  // The full-width index is kept for the range compare so high address bits
  // cannot alias onto a valid register after truncation.
  assign w_full_idx     = i_addr >> ADDR_LSB;
  assign w_misaligned   = (i_addr & LSB_MASK) != '0;
  assign w_out_of_range = w_full_idx > ADDR_WIDTH'(NUM_REGS);
  assign w_ro_write     = i_we && (w_full_idx == ADDR_WIDTH'(NUM_REGS));

  assign o_index = w_full_idx[IDX_W-1:0];
  assign o_kind  = (w_misaligned || w_out_of_range || w_ro_write) ? ERR : OK;

endmodule

// File: rtl/wb_regfile_slave.sv
// ---------------------------------------------------------------------------
// wb_regfile_slave
// Wishbone classic-cycle slave exposing NUM_REGS read/write registers with
// byte-lane writes plus a read-only status word at index NUM_REGS.
// Inserts WAIT_STATES cycles between accept and response.
//   clk, rstn     - clock (rising edge), asynchronous active-low reset
//   bus           - Wishbone slave modport (cyc/stb/we/addr/wdata/sel in,
//                   stall/ack/rdata/err out)
//   status_in     - read-only word, sampled when the response is produced
//   regs_out      - all registers flattened, register i at [i*DW +: DW]
//   reg_wr_pulse  - one-cycle pulse per register on every acked write
// ---------------------------------------------------------------------------
module wb_regfile_slave
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  wb_regfile_slave_if.slave              bus,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int IDX_W = idx_width(NUM_REGS);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int CNT_W = 4;

  state_t                r_state;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic                  r_we;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_sel;
  resp_kind_t            r_kind;

  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [IDX_W-1:0]      w_dec_idx;
  resp_kind_t            w_dec_kind;
  logic [DATA_WIDTH-1:0] w_rd_word;

  wb_regfile_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_decode (
    .i_addr  (bus.addr),
    .i_we    (bus.we),
    .o_index (w_dec_idx),
    .o_kind  (w_dec_kind)
  );

  // Read mux over the latched index; anything not matching a RW register is
  // the status word (errors never reach this mux's output).
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_rd_word = status_in;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_idx == IDX_W'(i)) w_rd_word = r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_sel      <= '0;
      r_kind     <= OK;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
      // NOTE: the register array is reset because it drives live control
      // signals into the datapath; this is flops, not an inferred RAM.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
      // Response outputs are single-cycle pulses unless RESP sets them.
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_wr_pulse <= '0;

      case (r_state)
        IDLE: begin
          if (bus.cyc && bus.stb) begin
            r_we    <= bus.we;
            r_idx   <= w_dec_idx;
            r_wdata <= bus.wdata;
            r_sel   <= bus.sel;
            r_kind  <= w_dec_kind;
            if (WAIT_STATES > 0) begin
              r_state    <= WAIT;
              r_wait_cnt <= CNT_W'(WAIT_STATES - 1);
            end else begin
              r_state <= RESP;
            end
          end
        end

        WAIT: begin
          // Master abandoning the cycle drops the request silently.
          if (!bus.cyc)                 r_state <= IDLE;
          else if (r_wait_cnt == '0)    r_state <= RESP;
          else                          r_wait_cnt <= r_wait_cnt - 1'b1;
        end

        RESP: begin
          r_state <= HOLD;
          if (r_kind == ERR) begin
            r_err <= 1'b1;
          end else begin
            r_ack <= 1'b1;
            if (r_we) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                  r_wr_pulse[i] <= 1'b1;
                  for (int b = 0; b < NB; b++) begin
                    if (r_sel[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                  end
                end
              end
            end else begin
              r_rdata <= w_rd_word;
            end
          end
        end

        HOLD: begin
          // Wait out the master's held strobe so one request is never served twice.
          if (!bus.stb || !bus.cyc) r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall    = (r_state != IDLE);
  assign bus.ack      = r_ack;
  assign bus.err      = r_err;
  assign bus.rdata    = r_rdata;
  assign reg_wr_pulse = r_wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: doc/wb_regfile_slave.md
# wb_regfile_slave

Wishbone slave register bank: the responder end of the team's Wishbone master interface and its `write_data`/`read_data` bench tasks. It accepts single classic-cycle requests and inserts a configurable number of wait states. It exposes `NUM_REGS` read/write registers with byte-lane writes plus one read-only status word, and flags illegal accesses with `err`. It sits behind the bus fabric and feeds control registers into the datapath.

## Interface
- `DATA_WIDTH`, 32: bus data width; multiple of 8.
- `ADDR_WIDTH`, 32: byte address width.
- `NUM_REGS`, 16: RW register count, 1..256.
- `WAIT_STATES`, 1: extra cycles between request accept and response, 0..15.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `cyc` in 1: bus cycle.
- `stb` in 1: request strobe.
- `we` in 1: 1 = write, 0 = read.
- `addr` in `ADDR_WIDTH`: byte address.
- `wdata` in `DATA_WIDTH`: write data.
- `sel` in `DATA_WIDTH/8`: byte-lane enables.
- `stall` out 1: slave cannot accept a request.
- `ack` out 1: one-cycle successful-response pulse.
- `rdata` out `DATA_WIDTH`: read data; valid only while `ack` is high.
- `err` out 1: one-cycle error-response pulse.
- `status_in` in `DATA_WIDTH`: read-only word at index `NUM_REGS`, sampled at response time.
- `regs_out` out `NUM_REGS*DATA_WIDTH`: register contents flattened; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `reg_wr_pulse` out `NUM_REGS`: bit i is high for one cycle when register i is written.

## Operation
- Index = `addr >> ADDR_LSB`, where ADDR_LSB = log2(`DATA_WIDTH/8`). The low ADDR_LSB bits must be zero.
- Error when any of the following holds:
  - the low ADDR_LSB address bits are nonzero;
  - index > `NUM_REGS`;
  - the access is a write to index `NUM_REGS`.
- An error asserts `err` instead of `ack`, leaves all registers unchanged, and drives `rdata` to 0.
- Writes update only lanes with `sel[b]`=1. A write with `sel`=0 is acked, changes nothing, but still pulses `reg_wr_pulse`.
- FSM states:
  - IDLE: `stall`=0. `cyc&&stb` sampled high at an edge means accept; latch `we`, index, `wdata`, `sel` and the error flag. Go to WAIT if `WAIT_STATES`>0, otherwise RESP.
  - WAIT: down-counter loaded with `WAIT_STATES`-1. Go to RESP when it reaches 0. If `cyc` is sampled low, abort to IDLE with no write and no response.
  - RESP: for exactly one cycle, `ack` or `err` is high. A write commits and `reg_wr_pulse` fires in this same cycle. `rdata` is loaded from the register or `status_in`. Unconditionally go to HOLD.
  - HOLD: `stall`=1. Return to IDLE at the first edge where `stb`=0 or `cyc`=0. This enforces classic-cycle semantics, because masters hold `stb` for at least one edge after `ack`; a held request is never accepted twice.
- `stall`=1 in WAIT, RESP and HOLD.
- Reset (async, any state): FSM goes to IDLE; `stall`, `ack`, `err`, `rdata`, `reg_wr_pulse` = 0; all registers = 0. Reset mid-transaction discards the request with no response.

## Timing
- Accept at edge E. `ack`/`err` rise at edge E+1+`WAIT_STATES` and fall at edge E+2+`WAIT_STATES`.
- Register contents and `regs_out` change at the same edge `ack` rises.
- `rdata` is nonzero only in the `ack` cycle. Read-after-write through back-to-back transactions returns the new value.
- All outputs are registered; there is no combinational path from inputs to `ack`, `err` or `rdata`.
- `stall` is a function of FSM state only.
- Minimum transaction spacing: one IDLE edge after `stb` falls.

## Structure
- Package `wb_regfile_pkg` holds:
  - the state enum (IDLE, WAIT, RESP, HOLD);
  - the ADDR_LSB computation function;
  - the response-kind typedef (OK, ERR).
- One sub-module, `wb_regfile_decode`: combinational index extraction plus misaligned/range/RO error detection, parameterised like the top.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x8 with `sel`=0xF, then read 0x8 → `ack` exactly one cycle, `rdata`=0xDEADBEEF, `reg_wr_pulse`[2] exactly one pulse.
- With reg 1 = 0x11223344, write 0xAABBCCDD with `sel`=0x5 → reads back 0x11BB33DD.
- Read index `NUM_REGS` (0x40) with `status_in`=0x0000CAFE → `ack`, `rdata`=0x0000CAFE. Write the same address → `err`, no `ack`, no register changes.
- Access addr 0x44 (out of range) and addr 0x2 (misaligned) → `err` for one cycle each, `rdata`=0, registers unchanged.
- `WAIT_STATES`=3: accept at edge E → `ack` at E+4. Holding `stb` high 1 cycle after `ack` → no second `ack`, and `stall`=1 until `stb` falls.
- Drop `cyc` during WAIT, and separately assert `rstn`=0 mid-WAIT → no `ack`/`err`, no write. After reset: all outputs 0 and `stall`=0.
